decoder38_buf: RTL and testbench

DECODER38_BUF -- requirements
Module: decoder38_buf

---
 rtl/decoder38_buf.sv | 120 ++++++++++++
 tb/tb_decoder38_buf.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder38_buf.sv
// Buffered 3-to-8 decoder: FIFO of codes, each held one-hot on y for HOLD enabled cycles.
// Ports: clk/rst_n; in_valid/in_ready/in_code push; en gates y; y/y_valid/busy/count status.
module decoder38_buf #(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_code,
  input  logic                   en,
  output logic [7:0]             y,
  output logic                   y_valid,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [7:0] HLD = 8'(HOLD - 1);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t        r_state;
  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_hold;
  logic [2:0]    r_code;
  logic [7:0]    r_y;
  logic          r_y_valid;

  logic          w_push;
  logic          w_pop;
  logic          w_hold0;
  logic [2:0]    w_head;

  function automatic logic [7:0] onehot(input logic [2:0] c);
    return 8'h01 << c;
  endfunction

  assign in_ready = r_count < FULL;
  assign w_push   = in_valid & in_ready;
  assign w_hold0  = r_hold == 8'd0;
  // Pop from IDLE, or back-to-back once the current code's hold expires.
  assign w_pop    = (r_count != '0) & en
                  & ((r_state == IDLE) | w_hold0);
  assign w_head   = r_mem[r_rptr];

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign count   = r_count;
  assign busy    = (r_count != '0) | (r_state == DRIVE);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_code    <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state   <= DRIVE;
            r_code    <= w_head;
            r_hold    <= HLD;
            r_y       <= onehot(w_head);
            r_y_valid <= 1'b1;
          end else begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
          end
        end
        DRIVE: begin
          if (!en) begin
            // Pause: blank output, keep code and remaining count.
            r_y       <= '0;
            r_y_valid <= 1'b0;
          end else if (!w_hold0) begin
            r_hold    <= r_hold - 8'd1;
            r_y       <= onehot(r_code);
            r_y_valid <= 1'b1;
          end else if (w_pop) begin
            r_code    <= w_head;
            r_hold    <= HLD;
            r_y       <= onehot(w_head);
            r_y_valid <= 1'b1;
          end else begin
            r_state   <= IDLE;
            r_y       <= '0;
            r_y_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder38_buf.sv
// Directed + randomized scoreboard bench for decoder38_buf.
// Two instances: HOLD=4 (main) and HOLD=1 (throughput).
module tb_decoder38_buf;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       en;
  logic [7:0] y;
  logic       y_valid;
  logic       busy;
  logic [2:0] count;

  logic       in_valid1;
  logic       in_ready1;
  logic [2:0] in_code1;
  logic       en1;
  logic [7:0] y1;
  logic       y_valid1;
  logic       busy1;
  logic [2:0] count1;

  int n_vec = 0;
  int n_err = 0;

  decoder38_buf #(.HOLD(4), .DEPTH(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .en       (en),
    .y        (y),
    .y_valid  (y_valid),
    .busy     (busy),
    .count    (count)
  );

  decoder38_buf #(.HOLD(1), .DEPTH(4)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .in_code  (in_code1),
    .en       (en1),
    .y        (y1),
    .y_valid  (y_valid1),
    .busy     (busy1),
    .count    (count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[$];
    int hc;
    bit acc;
    logic [7:0] one;
    one = 8'h01;

    rst_n = 1'b0;
    in_valid = 1'b0; in_code = 3'd0; en = 1'b1;
    in_valid1 = 1'b0; in_code1 = 3'd0; en1 = 1'b1;
    tick();
    tick();
    chk("rst_y", y, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_cnt", count, 0);
    rst_n = 1'b1;

    // Single code 5, HOLD=4
    in_valid = 1'b1; in_code = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("s_y0", y, 0);
    chk("s_cnt0", count, 1);
    chk("s_busy0", busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s_y", y, 32'h20);
      chk("s_yv", y_valid, 1);
    end
    tick();
    chk("s_yend", y, 0);
    chk("s_yvend", y_valid, 0);
    chk("s_busyend", busy, 0);

    // Full FIFO with en low
    en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_code = 3'(k + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("f_cnt", count, 4);
    chk("f_rdy", in_ready, 0);
    chk("f_y", y, 0);
    chk("f_busy", busy, 1);
    en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("f_order", y, one << (1 + j / 4));
      if (j == 0) chk("f_cnt1", count, 3);
    end
    tick();
    chk("f_yend", y, 0);
    chk("f_cntend", count, 0);

    // Pause mid-drive
    in_valid = 1'b1; in_code = 3'd2;
    tick();
    in_valid = 1'b0;
    tick(); chk("p_y1", y, 8'h04);
    tick(); chk("p_y2", y, 8'h04);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p_off", y, 0);
      chk("p_offv", y_valid, 0);
      chk("p_busy", busy, 1);
    end
    en = 1'b1;
    tick(); chk("p_y3", y, 8'h04);
    tick(); chk("p_y4", y, 8'h04);
    tick(); chk("p_end", y, 0);

    // Back-to-back, HOLD=1
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        in_valid1 = 1'b1; in_code1 = 3'(i);
        chk("b_rdy", in_ready1, 1);
      end else begin
        in_valid1 = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk("b_y", y1, one << (i - 1));
        chk("b_yv", y_valid1, 1);
      end
    end
    tick();
    chk("b_end", y1, 0);

    // Reset during DRIVE
    in_valid = 1'b1; in_code = 3'd3; tick();
    in_code = 3'd4; tick();
    in_code = 3'd7; tick();
    in_valid = 1'b0;
    chk("r_pre", y, 8'h08);
    chk("r_precnt", count, 2);
    rst_n = 1'b0;
    #1;
    chk("r_y", y, 0);
    chk("r_cnt", count, 0);
    chk("r_busy", busy, 0);
    chk("r_rdy", in_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("r_quiet", {busy, y_valid, y}, 0);
    end

    // Random traffic with scoreboard
    hc = 0;
    for (int c = 0; c < 1024; c++) begin
      if (c < 1000) begin
        in_valid = 1'($urandom_range(0, 1));
        in_code = 3'($urandom_range(0, 7));
        en = ($urandom_range(0, 9) < 8);
      end else begin
        in_valid = 1'b0;
        en = 1'b1;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) q.push_back(int'(in_code));
      if ($countones(y) > 1) chk("rnd_1hot", y, 0);
      if (!y_valid) begin
        if (y != 0) chk("rnd_blank", y, 0);
      end else if (q.size() == 0) begin
        chk("rnd_spur", y_valid, 0);
      end else begin
        chk("rnd_code", y, one << q[0]);
        hc++;
        if (hc == 4) begin
          void'(q.pop_front());
          hc = 0;
        end
      end
    end
    chk("rnd_drain", q.size(), 0);
    chk("rnd_hc", hc, 0);
    chk("rnd_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
